// File: rtl/hsv_cmd_arbiter_if.sv
// rtl/hsv_cmd_arbiter_if.sv - requester handshakes and command outputs of hsv_cmd_arbiter
interface hsv_cmd_arbiter_if;
  logic        a_valid;
  logic [1:0]  a_mode;
  logic [8:0]  a_hue;
  logic [7:0]  a_sat;
  logic [7:0]  a_val;
  logic        a_ready;
  logic        b_valid;
  logic [1:0]  b_mode;
  logic [8:0]  b_hue;
  logic [7:0]  b_sat;
  logic [7:0]  b_val;
  logic        b_ready;
  logic        err_clr;
  logic [26:0] cmd_data;
  logic        cmd_load;
  logic        cmd_busy;
  logic        last_grant;
  logic        err_hue;

  modport master (
    output a_valid, a_mode, a_hue, a_sat, a_val,
    output b_valid, b_mode, b_hue, b_sat, b_val,
    output err_clr,
    input  a_ready, b_ready, cmd_data, cmd_load, cmd_busy, last_grant, err_hue
  );

  modport slave (
    input  a_valid, a_mode, a_hue, a_sat, a_val,
    input  b_valid, b_mode, b_hue, b_sat, b_val,
    input  err_clr,
    output a_ready, b_ready, cmd_data, cmd_load, cmd_busy, last_grant, err_hue
  );
endinterface

// File: rtl/hsv_cmd_arbiter.sv
// rtl/hsv_cmd_arbiter.sv - round-robin arbiter for two HSV command requesters with hue fix-up, duplicate drop and post-issue gap
module hsv_cmd_arbiter #(
  parameter logic [23:0] GAP_CYCLES   = 24'd99999,
  parameter logic        SUPPRESS_DUP = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  hsv_cmd_arbiter_if.slave bus
);
  localparam logic [26:0] RESET_CMD = {8'd80, 8'd80, 9'd0, 2'd0};

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

  state_e      state_q;
  logic [23:0] gap_cnt_q;
  logic        last_grant_q;
  logic        err_hue_q;
  logic        err_hue_d;
  logic        cmd_load_q;
  logic        cmd_busy_q;
  logic [26:0] last_cmd_q;

  logic        idle;
  logic        a_ready;
  logic        b_ready;
  logic        xfer;
  logic        hue_bad;
  logic        suppress;
  logic [1:0]  sel_mode;
  logic [8:0]  sel_hue;
  logic [8:0]  hue_fix;
  logic [7:0]  sel_sat;
  logic [7:0]  sel_val;
  logic [26:0] pkt;

  // On a tie the requester that did not win last time is served.
  assign idle    = (state_q == IDLE);
  assign a_ready = idle & bus.a_valid & (~bus.b_valid | last_grant_q);
  assign b_ready = idle & bus.b_valid & (~bus.a_valid | ~last_grant_q);
  assign xfer    = a_ready | b_ready;

  always_comb begin
    sel_mode = bus.a_mode;
    sel_hue  = bus.a_hue;
    sel_sat  = bus.a_sat;
    sel_val  = bus.a_val;
    if (b_ready) begin
      sel_mode = bus.b_mode;
      sel_hue  = bus.b_hue;
      sel_sat  = bus.b_sat;
      sel_val  = bus.b_val;
    end
  end

  assign hue_bad   = (sel_hue >= 9'd360);
  assign hue_fix   = hue_bad ? (sel_hue - 9'd360) : sel_hue;
  assign pkt       = {sel_val, sel_sat, hue_fix, sel_mode};
  assign suppress  = SUPPRESS_DUP && (pkt == last_cmd_q);
  assign err_hue_d = (xfer & hue_bad) | (err_hue_q & ~bus.err_clr);

  // last_cmd_q is both the issued-command output and the reference for duplicate suppression.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      gap_cnt_q    <= 24'd0;
      last_grant_q <= 1'b1;
      err_hue_q    <= 1'b0;
      cmd_load_q   <= 1'b0;
      cmd_busy_q   <= 1'b0;
      last_cmd_q   <= RESET_CMD;
    end else begin
      err_hue_q <= err_hue_d;
      if (xfer) begin
        last_grant_q <= b_ready;
      end
      case (state_q)
        IDLE: begin
          if (xfer && !suppress) begin
            state_q    <= ISSUE;
            last_cmd_q <= pkt;
            cmd_load_q <= 1'b1;
            cmd_busy_q <= 1'b1;
          end
        end
        ISSUE: begin
          cmd_load_q <= 1'b0;
          if (GAP_CYCLES != 24'd0) begin
            state_q   <= GAP;
            gap_cnt_q <= 24'd0;
          end else begin
            state_q    <= IDLE;
            cmd_busy_q <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_CYCLES - 24'd1) begin
            state_q    <= IDLE;
            cmd_busy_q <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 24'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          cmd_load_q <= 1'b0;
          cmd_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_ready    = a_ready;
  assign bus.b_ready    = b_ready;
  assign bus.cmd_data   = last_cmd_q;
  assign bus.cmd_load   = cmd_load_q;
  assign bus.cmd_busy   = cmd_busy_q;
  assign bus.last_grant = last_grant_q;
  assign bus.err_hue    = err_hue_q;
endmodule

// File: tb/tb_hsv_cmd_arbiter.sv
// tb/tb_hsv_cmd_arbiter.sv - self-checking bench for hsv_cmd_arbiter against a cycle-count reference model
module tb_hsv_cmd_arbiter;
  localparam logic [23:0] GAP     = 24'd4;
  localparam logic [26:0] RST_CMD = {8'd80, 8'd80, 9'd0, 2'd0};

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  hsv_cmd_arbiter_if bus ();

  hsv_cmd_arbiter #(.GAP_CYCLES(GAP), .SUPPRESS_DUP(1'b1)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: busy is a countdown of cycles left before requests are served again.
  int          m_busy;
  logic        m_lg;
  logic [26:0] m_cmd;
  logic        m_err;
  logic        m_load;
  logic        m_xfer;

  logic g_a_rdy, g_b_rdy, g_busy, g_load;
  int   load_cyc[$];

  logic [8:0] hue_pool[7] = '{9'd0, 9'd60, 9'd120, 9'd359, 9'd360, 9'd400, 9'd511};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_lg   = 1'b1;
    m_cmd  = RST_CMD;
    m_err  = 1'b0;
    m_load = 1'b0;
    m_xfer = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.a_valid = 1'b0; bus.a_mode = 2'd0; bus.a_hue = 9'd0; bus.a_sat = 8'd0; bus.a_val = 8'd0;
    bus.b_valid = 1'b0; bus.b_mode = 2'd0; bus.b_hue = 9'd0; bus.b_sat = 8'd0; bus.b_val = 8'd0;
    bus.err_clr = 1'b0;
  endtask

  task automatic step();
    logic       ea, eb, bad;
    logic [1:0] md;
    logic [8:0] h, hc;
    logic [7:0] s, v;
    @(negedge clk_i);
    ea = (m_busy == 0) && bus.a_valid && (!bus.b_valid || m_lg);
    eb = (m_busy == 0) && bus.b_valid && (!bus.a_valid || !m_lg);
    g_a_rdy = bus.a_ready;
    g_b_rdy = bus.b_ready;
    g_busy  = bus.cmd_busy;
    g_load  = bus.cmd_load;
    if (g_load) load_cyc.push_back(cyc);
    check("a_ready",    32'(bus.a_ready),    32'(ea));
    check("b_ready",    32'(bus.b_ready),    32'(eb));
    check("cmd_load",   32'(bus.cmd_load),   32'(m_load));
    check("cmd_data",   32'(bus.cmd_data),   32'(m_cmd));
    check("cmd_busy",   32'(bus.cmd_busy),   32'(m_busy != 0));
    check("last_grant", 32'(bus.last_grant), 32'(m_lg));
    check("err_hue",    32'(bus.err_hue),    32'(m_err));
    md  = eb ? bus.b_mode : bus.a_mode;
    h   = eb ? bus.b_hue  : bus.a_hue;
    s   = eb ? bus.b_sat  : bus.a_sat;
    v   = eb ? bus.b_val  : bus.a_val;
    bad = (h >= 9'd360);
    hc  = bad ? h - 9'd360 : h;
    m_xfer = ea || eb;
    m_err  = (m_xfer && bad) || (m_err && !bus.err_clr);
    m_load = 1'b0;
    if (m_busy != 0) m_busy--;
    if (m_xfer) begin
      m_lg = eb;
      if ({v, s, hc, md} != m_cmd) begin
        m_cmd  = {v, s, hc, md};
        m_load = 1'b1;
        m_busy = 32'(GAP) + 1;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_i = 1'b0;
    model_reset();
    step();
    step();
    reset_i = 1'b1;
  endtask

  task automatic send(input logic use_b, input logic [1:0] md, input logic [8:0] h,
                      input logic [7:0] s, input logic [7:0] v, input string tag);
    int n = 0;
    if (use_b) begin
      bus.b_valid = 1'b1; bus.b_mode = md; bus.b_hue = h; bus.b_sat = s; bus.b_val = v;
    end else begin
      bus.a_valid = 1'b1; bus.a_mode = md; bus.a_hue = h; bus.a_sat = s; bus.a_val = v;
    end
    do begin
      step();
      n++;
    end while (!(use_b ? g_b_rdy : g_a_rdy) && n < 40);
    check({tag, "_accept"}, 32'(use_b ? g_b_rdy : g_a_rdy), 32'd1);
    if (use_b) bus.b_valid = 1'b0;
    else bus.a_valid = 1'b0;
  endtask

  initial begin
    int k, nb, prev_grant, first_b;
    clear_inputs();
    model_reset();
    do_reset();

    // Reset-valued command straight after reset: accepted but dropped.
    send(1'b0, 2'd0, 9'd0, 8'd80, 8'd80, "r034");
    for (int i = 0; i < 3; i++) step();
    check("r034_busy", 32'(bus.cmd_busy), 32'd0);

    // Single issue, then the earliest next grant to A.
    send(1'b0, 2'd1, 9'd120, 8'd200, 8'd100, "r031");
    check("r031_data", 32'(bus.cmd_data), 32'({8'd100, 8'd200, 9'd120, 2'd1}));
    bus.a_valid = 1'b1; bus.a_mode = 2'd2; bus.a_hue = 9'd5; bus.a_sat = 8'd7; bus.a_val = 8'd9;
    k = 0; nb = 0;
    do begin
      step();
      k++;
      nb += int'(g_busy);
    end while (!g_a_rdy && k < 20);
    bus.a_valid = 1'b0;
    check("r031_next_ready", 32'(k), 32'd6);
    check("r031_busy_len", 32'(nb), 32'd5);

    // Out-of-range hue, sticky error, clear, and set-wins.
    send(1'b1, 2'd2, 9'd400, 8'd10, 8'd20, "r033");
    check("r033_hue", 32'(bus.cmd_data[10:2]), 32'd40);
    check("r033_err", 32'(bus.err_hue), 32'd1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    step();
    check("r033_clr", 32'(bus.err_hue), 32'd0);
    bus.err_clr = 1'b1;
    send(1'b1, 2'd3, 9'd450, 8'd11, 8'd22, "r022");
    bus.err_clr = 1'b0;
    check("r022_setwins", 32'(bus.err_hue), 32'd1);

    // Tie from reset: A first, B after the gap.
    do_reset();
    load_cyc.delete();
    first_b = -1;
    bus.a_valid = 1'b1; bus.a_mode = 2'd1; bus.a_hue = 9'd10; bus.a_sat = 8'd1; bus.a_val = 8'd2;
    bus.b_valid = 1'b1; bus.b_mode = 2'd2; bus.b_hue = 9'd20; bus.b_sat = 8'd3; bus.b_val = 8'd4;
    for (int i = 0; i < 12; i++) begin
      step();
      if ((g_a_rdy || g_b_rdy) && first_b < 0) first_b = int'(g_b_rdy);
      if (g_a_rdy) bus.a_valid = 1'b0;
      if (g_b_rdy) bus.b_valid = 1'b0;
    end
    check("r032_first_is_a", 32'(first_b), 32'd0);
    check("r032_loads", 32'(load_cyc.size()), 32'd2);
    if (load_cyc.size() == 2) check("r032_spacing", 32'(load_cyc[1] - load_cyc[0]), 32'd6);
    check("r032_lg_b", 32'(bus.last_grant), 32'd1);

    // Reset during gap cycle 2 aborts asynchronously.
    send(1'b0, 2'd1, 9'd33, 8'd44, 8'd55, "r035");
    k = 0;
    while (m_busy != 3 && k < 10) begin
      step();
      k++;
    end
    #2 reset_i = 1'b0;
    #1;
    model_reset();
    check("r035_busy", 32'(bus.cmd_busy), 32'd0);
    check("r035_load", 32'(bus.cmd_load), 32'd0);
    check("r035_data", 32'(bus.cmd_data), 32'(RST_CMD));
    check("r035_lg",   32'(bus.last_grant), 32'd1);
    step();
    reset_i = 1'b1;
    load_cyc.delete();
    for (int i = 0; i < 8; i++) step();
    check("r035_no_load", 32'(load_cyc.size()), 32'd0);

    // B always valid, A pulsing every third cycle; inputs change freely while not ready.
    prev_grant = -1;
    for (int i = 0; i < 90; i++) begin
      bus.a_valid = ((i % 3) == 0);
      bus.a_mode = 2'($urandom_range(0, 3)); bus.a_hue = 9'($urandom_range(0, 511));
      bus.a_sat  = 8'($urandom);            bus.a_val = 8'($urandom);
      bus.b_valid = 1'b1;
      bus.b_mode = 2'($urandom_range(0, 3)); bus.b_hue = 9'($urandom_range(0, 511));
      bus.b_sat  = 8'($urandom);            bus.b_val = 8'($urandom);
      step();
      if (g_a_rdy || g_b_rdy) begin
        if (bus.a_valid && bus.b_valid && prev_grant >= 0)
          check("r036_alternate", 32'(g_b_rdy), 32'(prev_grant == 0));
        prev_grant = int'(g_b_rdy);
      end
    end

    // Random traffic drawn from a small pool so duplicates and hue errors recur.
    for (int i = 0; i < 300; i++) begin
      bus.a_valid = ($urandom_range(0, 2) != 0);
      bus.a_mode = 2'($urandom_range(0, 1)); bus.a_hue = hue_pool[$urandom_range(0, 6)];
      bus.a_sat  = ($urandom_range(0, 1) != 0) ? 8'd80 : 8'd200;
      bus.a_val  = ($urandom_range(0, 1) != 0) ? 8'd80 : 8'd100;
      bus.b_valid = ($urandom_range(0, 2) != 0);
      bus.b_mode = 2'($urandom_range(0, 1)); bus.b_hue = hue_pool[$urandom_range(0, 6)];
      bus.b_sat  = ($urandom_range(0, 1) != 0) ? 8'd80 : 8'd200;
      bus.b_val  = ($urandom_range(0, 1) != 0) ? 8'd80 : 8'd100;
      bus.err_clr = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
